// File: rtl/logic_pod_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module : logic_pod_capture_ctrl
// Brief  : Write-side capture sequencer for one 8-lane logic pod sample buffer
//          (arm, pre-trigger fill, wait-for-trigger, post-trigger countdown).
// Rev    : 1.0  initial release
// ============================================================================
module logic_pod_capture_ctrl #(
    parameter int DEPTH_BITS = 12
) (
    input  logic                  clk_250mhz,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  trigger,
    input  logic [DEPTH_BITS-1:0] pretrig_len,
    input  logic [DEPTH_BITS-1:0] posttrig_len,
    output logic                  wr_en,
    output logic [DEPTH_BITS-1:0] wr_addr,
    output logic                  busy,
    output logic                  done,
    output logic [DEPTH_BITS-1:0] trig_addr,
    output logic [DEPTH_BITS-1:0] start_addr
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PREFILL = 3'd1,
        S_ARMED   = 3'd2,
        S_POST    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [DEPTH_BITS-1:0] c_ZERO = '0;
    localparam logic [DEPTH_BITS-1:0] c_ONE  = DEPTH_BITS'(1);
    localparam logic [DEPTH_BITS-1:0] c_MAX  = '1;

    state_t                r_state, w_state;
    logic                  r_wr_en, w_wr_en;
    logic                  r_busy, w_busy;
    logic                  r_done, w_done;
    logic [DEPTH_BITS-1:0] r_wr_addr, w_wr_addr;
    logic [DEPTH_BITS-1:0] r_trig_addr, w_trig_addr;
    logic [DEPTH_BITS-1:0] r_start_addr, w_start_addr;
    logic [DEPTH_BITS-1:0] r_pre, w_pre;
    logic [DEPTH_BITS-1:0] r_post, w_post;
    logic [DEPTH_BITS-1:0] r_cnt, w_cnt;
    logic [DEPTH_BITS-1:0] w_room;
    logic [DEPTH_BITS-1:0] w_post_clamp;
    logic [DEPTH_BITS-1:0] w_addr_inc;

    // Post length is clamped so pre + 1 + post never exceeds the buffer depth.
    assign w_room       = c_MAX - pretrig_len;
    assign w_post_clamp = (posttrig_len > w_room) ? w_room : posttrig_len;
    assign w_addr_inc   = r_wr_addr + c_ONE;

    always_comb begin
        w_state      = r_state;
        w_wr_en      = r_wr_en;
        w_busy       = r_busy;
        w_done       = r_done;
        w_wr_addr    = r_wr_addr;
        w_trig_addr  = r_trig_addr;
        w_start_addr = r_start_addr;
        w_pre        = r_pre;
        w_post       = r_post;
        w_cnt        = r_cnt;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    w_pre     = pretrig_len;
                    w_post    = w_post_clamp;
                    w_wr_addr = c_ZERO;
                    w_cnt     = c_ZERO;
                    w_wr_en   = 1'b1;
                    w_busy    = 1'b1;
                    w_done    = 1'b0;
                    w_state   = (pretrig_len == c_ZERO) ? S_ARMED : S_PREFILL;
                end
            end
            S_PREFILL: begin
                w_cnt     = r_cnt + c_ONE;
                w_wr_addr = w_addr_inc;
                if (r_cnt == r_pre - c_ONE) begin
                    w_state = S_ARMED;
                end
            end
            S_ARMED: begin
                if (trigger) begin
                    w_trig_addr  = r_wr_addr;
                    w_start_addr = r_wr_addr - r_pre;
                    if (r_post == c_ZERO) begin
                        // Trigger word was the last write; address holds on it.
                        w_state = S_DONE;
                        w_wr_en = 1'b0;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                    end else begin
                        w_state   = S_POST;
                        w_cnt     = r_post;
                        w_wr_addr = w_addr_inc;
                    end
                end else begin
                    w_wr_addr = w_addr_inc;
                end
            end
            S_POST: begin
                if (r_cnt == c_ONE) begin
                    w_state = S_DONE;
                    w_wr_en = 1'b0;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                end else begin
                    w_cnt     = r_cnt - c_ONE;
                    w_wr_addr = w_addr_inc;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_wr_en = 1'b0;
                w_busy  = 1'b0;
                w_done  = 1'b0;
            end
        endcase

        // Abort overrides everything; result addresses from the last capture survive.
        if (abort) begin
            w_state      = S_IDLE;
            w_wr_en      = 1'b0;
            w_busy       = 1'b0;
            w_done       = 1'b0;
            w_wr_addr    = r_wr_addr;
            w_trig_addr  = r_trig_addr;
            w_start_addr = r_start_addr;
        end
    end

    always_ff @(posedge clk_250mhz) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wr_en      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_wr_addr    <= c_ZERO;
            r_trig_addr  <= c_ZERO;
            r_start_addr <= c_ZERO;
            r_pre        <= c_ZERO;
            r_post       <= c_ZERO;
            r_cnt        <= c_ZERO;
        end else begin
            r_state      <= w_state;
            r_wr_en      <= w_wr_en;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_wr_addr    <= w_wr_addr;
            r_trig_addr  <= w_trig_addr;
            r_start_addr <= w_start_addr;
            r_pre        <= w_pre;
            r_post       <= w_post;
            r_cnt        <= w_cnt;
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign busy       = r_busy;
    assign done       = r_done;
    assign trig_addr  = r_trig_addr;
    assign start_addr = r_start_addr;

endmodule
`default_nettype wire

// File: tb/tb_logic_pod_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_logic_pod_capture_ctrl
// Brief  : Self-checking bench for logic_pod_capture_ctrl with a 16-word buffer.
// Rev    : 1.0  initial release
// ============================================================================
module tb_logic_pod_capture_ctrl;

    localparam int DB = 4;
    localparam int D  = 16;

    logic          clk_250mhz = 1'b0;
    logic          rst        = 1'b1;
    logic          arm        = 1'b0;
    logic          abort      = 1'b0;
    logic          trigger    = 1'b0;
    logic [DB-1:0] pretrig_len  = '0;
    logic [DB-1:0] posttrig_len = '0;
    logic          wr_en;
    logic [DB-1:0] wr_addr;
    logic          busy;
    logic          done;
    logic [DB-1:0] trig_addr;
    logic [DB-1:0] start_addr;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int wen_cnt = 0;

    // Model: a capture is a sequence of writes indexed 0,1,2...; write k lands at k mod D.
    bit m_active     = 1'b0;
    bit m_done       = 1'b0;
    int m_n          = 0;
    int m_pre        = 0;
    int m_post       = 0;
    int m_trig       = -1;
    int m_trig_addr  = 0;
    int m_start_addr = 0;
    int m_hold       = 0;

    logic_pod_capture_ctrl #(.DEPTH_BITS(DB)) dut (
        .clk_250mhz  (clk_250mhz),
        .rst         (rst),
        .arm         (arm),
        .abort       (abort),
        .trigger     (trigger),
        .pretrig_len (pretrig_len),
        .posttrig_len(posttrig_len),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .busy        (busy),
        .done        (done),
        .trig_addr   (trig_addr),
        .start_addr  (start_addr)
    );

    always #5 clk_250mhz = ~clk_250mhz;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk_250mhz) begin : model
        if (rst) begin
            m_active = 1'b0; m_done = 1'b0; m_n = 0; m_trig = -1;
            m_trig_addr = 0; m_start_addr = 0; m_hold = 0;
        end else if (abort) begin
            if (m_active) m_hold = m_n % D;
            m_active = 1'b0;
            m_done   = 1'b0;
        end else if (!m_active) begin
            if (arm) begin
                m_active = 1'b1;
                m_done   = 1'b0;
                m_n      = 0;
                m_trig   = -1;
                m_pre    = int'(pretrig_len);
                m_post   = (int'(posttrig_len) < D - 1 - m_pre) ? int'(posttrig_len) : D - 1 - m_pre;
            end
        end else begin
            if (m_trig < 0 && m_n >= m_pre && trigger) begin
                m_trig       = m_n;
                m_trig_addr  = m_n % D;
                m_start_addr = (m_n - m_pre) % D;
            end
            m_n++;
            if (m_trig >= 0 && m_n == m_trig + 1 + m_post) begin
                m_active = 1'b0;
                m_done   = 1'b1;
                m_hold   = (m_n - 1) % D;
            end
        end
    end

    always @(negedge clk_250mhz) begin : compare
        chk("wr_en", int'(wr_en), int'(m_active));
        chk("wr_addr", int'(wr_addr), m_active ? (m_n % D) : m_hold);
        chk("busy", int'(busy), int'(m_active));
        chk("done", int'(done), int'(m_done));
        chk("trig_addr", int'(trig_addr), m_trig_addr);
        chk("start_addr", int'(start_addr), m_start_addr);
        if (wr_en) wen_cnt++;
    end

    task automatic step();
        @(posedge clk_250mhz);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int at);
        int k;
        k = 0;
        while (!done && k < limit) begin
            step();
            k++;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_done: no done within %0d cycles", limit);
        end
        at = cyc;
    endtask

    initial begin
        int t;
        int w0;
        #1;
        do_reset();
        chk("reset_wr_en", int'(wr_en), 0);
        chk("reset_busy", int'(busy), 0);

        // Basic capture
        pretrig_len = 4'd3; posttrig_len = 4'd4;
        arm = 1'b1; cyc = 0; w0 = wen_cnt;
        step(); arm = 1'b0;
        repeat (9) step();
        trigger = 1'b1; step(); trigger = 1'b0;
        wait_done(40, t);
        chk("basic_done_cycle", t, 15);
        chk("basic_trig_addr", int'(trig_addr), 9);
        chk("basic_start_addr", int'(start_addr), 6);
        chk("basic_wr_count", wen_cnt - w0, 14);
        chk("basic_model_trig", m_trig_addr, 9);

        // Early trigger held through PREFILL
        do_reset();
        arm = 1'b1; cyc = 0;
        step(); arm = 1'b0; trigger = 1'b1;
        wait_done(40, t);
        trigger = 1'b0;
        chk("early_done_cycle", t, 9);
        chk("early_trig_addr", int'(trig_addr), 3);
        chk("early_start_addr", int'(start_addr), 0);

        // Wrap and clamp, re-armed from DONE
        pretrig_len = 4'd10; posttrig_len = 4'd15;
        arm = 1'b1; cyc = 0; w0 = wen_cnt;
        step(); arm = 1'b0;
        repeat (30) step();
        trigger = 1'b1; step(); trigger = 1'b0;
        wait_done(40, t);
        chk("wrap_model_post", m_post, 5);
        chk("wrap_done_cycle", t, 37);
        chk("wrap_trig_addr", int'(trig_addr), 14);
        chk("wrap_start_addr", int'(start_addr), 4);
        chk("wrap_wr_count", wen_cnt - w0, 36);

        // Zero lengths
        pretrig_len = 4'd0; posttrig_len = 4'd0;
        arm = 1'b1; w0 = wen_cnt;
        step(); arm = 1'b0;
        chk("zero_first_addr", int'(wr_addr), 0);
        chk("zero_first_wr_en", int'(wr_en), 1);
        trigger = 1'b1; step(); trigger = 1'b0;
        chk("zero_done", int'(done), 1);
        chk("zero_trig_addr", int'(trig_addr), 0);
        chk("zero_start_addr", int'(start_addr), 0);
        chk("zero_wr_count", wen_cnt - w0, 1);

        // Abort together with arm
        arm = 1'b1; abort = 1'b1;
        step(); arm = 1'b0; abort = 1'b0;
        chk("abort_arm_busy", int'(busy), 0);
        chk("abort_arm_done", int'(done), 0);

        // Abort in POST
        pretrig_len = 4'd2; posttrig_len = 4'd6;
        arm = 1'b1; step(); arm = 1'b0;
        repeat (2) step();
        trigger = 1'b1; step(); trigger = 1'b0;
        step();
        abort = 1'b1; step(); abort = 1'b0;
        chk("abort_post_wr_en", int'(wr_en), 0);
        chk("abort_post_busy", int'(busy), 0);
        chk("abort_post_done", int'(done), 0);
        chk("abort_post_trig_addr", int'(trig_addr), 2);

        // Short capture to DONE, then re-arm restarts at address 0
        pretrig_len = 4'd1; posttrig_len = 4'd1;
        arm = 1'b1; step(); arm = 1'b0;
        step();
        trigger = 1'b1; step(); trigger = 1'b0;
        step();
        chk("short_done", int'(done), 1);
        chk("short_hold_addr", int'(wr_addr), 2);
        arm = 1'b1; step(); arm = 1'b0;
        chk("rearm_addr", int'(wr_addr), 0);
        chk("rearm_wr_en", int'(wr_en), 1);

        // Reset mid-ARMED, then a trigger right after release
        step();
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_trig_addr", int'(trig_addr), 0);
        trigger = 1'b1; step(); trigger = 1'b0;
        step();
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_done", int'(done), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst          = ($urandom % 400) == 0;
            arm          = ($urandom % 8) == 0;
            abort        = ($urandom % 64) == 0;
            trigger      = ($urandom % 6) == 0;
            pretrig_len  = DB'($urandom % D);
            posttrig_len = DB'($urandom % D);
            step();
        end
        rst = 1'b0; arm = 1'b0; abort = 1'b0; trigger = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
